// File: rtl/fifo_reg_rd_arb.sv
// Two-requester read port onto the FIFO status registers.
// One read is in flight at a time: IDLE (grant), CAPTURE (sample), RESP (hold until consumed).
module fifo_reg_rd_arb #(
    parameter int ADDR    = 10,
    parameter int ERRPTR  = 4,
    parameter int WIDTH   = 32,
    parameter int ERRDATA = 6
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    input  logic [2:0]         req0_addr,
    output logic               req0_ready,
    output logic               rsp0_valid,
    output logic [WIDTH-1:0]   rsp0_data,
    output logic               rsp0_err,
    input  logic               rsp0_ready,

    input  logic               req1_valid,
    input  logic [2:0]         req1_addr,
    output logic               req1_ready,
    output logic               rsp1_valid,
    output logic [WIDTH-1:0]   rsp1_data,
    output logic               rsp1_err,
    input  logic               rsp1_ready,

    input  logic [WIDTH-1:0]   fifo_out_reg,
    input  logic [ERRDATA-1:0] data_err_idx_reg,
    input  logic [ADDR-1:0]    wr_ptr_reg,
    input  logic [ERRPTR-1:0]  wr_ptr_err_idx_reg,
    input  logic [ADDR-1:0]    rd_ptr_reg,
    input  logic [ERRPTR-1:0]  rd_ptr_err_idx_reg,

    output logic [15:0]        err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic              sel;
    logic              any_valid;
    logic              own_rsp_ready;
    logic [2:0]        addr_q;
    logic [WIDTH-1:0]  data_q;
    logic              err_q;
    logic [15:0]       err_cnt_q;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_err;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // On a tie the requester that was not served last wins.
    assign any_valid     = req0_valid | req1_valid;
    assign sel           = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign own_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (addr_q)
            3'd0:    rd_data = fifo_out_reg;
            3'd1:    rd_data = WIDTH'(data_err_idx_reg);
            3'd2:    rd_data = WIDTH'(wr_ptr_reg);
            3'd3:    rd_data = WIDTH'(wr_ptr_err_idx_reg);
            3'd4:    rd_data = WIDTH'(rd_ptr_reg);
            3'd5:    rd_data = WIDTH'(rd_ptr_err_idx_reg);
            default: rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    state_nxt  = CAPTURE;
                end
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                if (own_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant stage: latch owner and address on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                owner  <= sel;
                addr_q <= sel ? req1_addr : req0_addr;
            end
            if (state == RESP && own_rsp_ready) last_grant <= owner;
        end
    end

    // Capture stage: registers are sampled once; the response stays frozen afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (state == CAPTURE) begin
            data_q <= rd_data;
            err_q  <= rd_err;
            if (rd_err) err_cnt_q <= sat_inc16(err_cnt_q);
        end
    end

    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) & owner;
    assign rsp0_data  = rsp0_valid ? data_q : '0;
    assign rsp1_data  = rsp1_valid ? data_q : '0;
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_err   = rsp1_valid & err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fifo_reg_rd_arb.sv
// Directed bench for fifo_reg_rd_arb: arbitration, register mux, stall, reset abort, error count.
module tb_fifo_reg_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] fifo_out_reg;
    logic [5:0]  data_err_idx_reg;
    logic [9:0]  wr_ptr_reg;
    logic [3:0]  wr_ptr_err_idx_reg;
    logic [9:0]  rd_ptr_reg;
    logic [3:0]  rd_ptr_err_idx_reg;
    logic [15:0] err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_reg_rd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
        .fifo_out_reg(fifo_out_reg), .data_err_idx_reg(data_err_idx_reg),
        .wr_ptr_reg(wr_ptr_reg), .wr_ptr_err_idx_reg(wr_ptr_err_idx_reg),
        .rd_ptr_reg(rd_ptr_reg), .rd_ptr_err_idx_reg(rd_ptr_err_idx_reg),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge in IDLE; returns just after a negedge back in IDLE.
    task automatic read_txn(input bit n, input logic [2:0] a, input logic [31:0] exp_d,
                            input logic exp_e);
        if (n) begin req1_valid = 1'b1; req1_addr = a; end
        else   begin req0_valid = 1'b1; req0_addr = a; end
        #1;
        chk("rd_ready",   n ? req1_ready : req0_ready, 1);
        chk("rd_ready_o", n ? req0_ready : req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cap_valid", n ? rsp1_valid : rsp0_valid, 0);
        @(negedge clk);
        chk("rsp_valid",   n ? rsp1_valid : rsp0_valid, 1);
        chk("rsp_data",    n ? rsp1_data  : rsp0_data,  exp_d);
        chk("rsp_err",     n ? rsp1_err   : rsp0_err,   exp_e);
        chk("rsp_valid_o", n ? rsp0_valid : rsp1_valid, 0);
        chk("rsp_data_o",  n ? rsp0_data  : rsp1_data,  0);
        if (n) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        chk("done_valid", n ? rsp1_valid : rsp0_valid, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 3'd0;  req1_addr = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        fifo_out_reg       = 32'hDEADBEEF;
        data_err_idx_reg   = 6'h2A;
        wr_ptr_reg         = 10'h155;
        wr_ptr_err_idx_reg = 4'h9;
        rd_ptr_reg         = 10'h3FF;
        rd_ptr_err_idx_reg = 4'h5;
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_err_cnt",    err_cnt, 0);
        chk("rst_rsp0_data",  rsp0_data, 0);

        // Tie after reset: 0, then 1, then 0 again.
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 3'd0;
        req1_valid = 1'b1; req1_addr = 3'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("tie1_r0_ready", req0_ready, 1);
        chk("tie1_r1_ready", req1_ready, 0);
        @(negedge clk);
        chk("tie_cap_r0_ready", req0_ready, 0);
        chk("tie_cap_r1_ready", req1_ready, 0);
        @(negedge clk);
        chk("tie1_rsp0_valid", rsp0_valid, 1);
        chk("tie1_rsp0_data",  rsp0_data, 32'hDEADBEEF);
        chk("tie1_rsp1_valid", rsp1_valid, 0);
        @(negedge clk);
        chk("tie2_r1_ready", req1_ready, 1);
        chk("tie2_r0_ready", req0_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("tie2_rsp1_valid", rsp1_valid, 1);
        chk("tie2_rsp1_data",  rsp1_data, 32'h000003FF);
        chk("tie2_rsp0_valid", rsp0_valid, 0);
        @(negedge clk);
        chk("tie3_r0_ready", req0_ready, 1);
        chk("tie3_r1_ready", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);

        // Every valid register address, from both requesters.
        read_txn(1'b0, 3'd2, 32'h00000155, 1'b0);
        read_txn(1'b1, 3'd0, 32'hDEADBEEF, 1'b0);
        read_txn(1'b0, 3'd1, 32'h0000002A, 1'b0);
        read_txn(1'b1, 3'd3, 32'h00000009, 1'b0);
        read_txn(1'b0, 3'd4, 32'h000003FF, 1'b0);
        read_txn(1'b1, 3'd5, 32'h00000005, 1'b0);
        chk("valid_err_cnt", err_cnt, 0);

        // Invalid addresses.
        for (int i = 0; i < 3; i++) read_txn(1'b1, 3'd7, 32'h0, 1'b1);
        chk("inv_err_cnt3", err_cnt, 3);
        read_txn(1'b0, 3'd6, 32'h0, 1'b1);
        chk("inv_err_cnt4", err_cnt, 4);

        // Stall with changing register and a competing request.
        req0_valid = 1'b1; req0_addr = 3'd0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 3'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",     rsp0_valid, 1);
            chk("stall_data",      rsp0_data, 32'hDEADBEEF);
            chk("stall_r1_ready",  req1_ready, 0);
            fifo_out_reg = 32'h10000000 + i;
            @(negedge clk);
        end
        chk("stall_end_valid", rsp0_valid, 1);
        rsp0_ready = 1'b1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("stall_done_valid", rsp0_valid, 0);
        rsp0_ready = 1'b0;
        fifo_out_reg = 32'hDEADBEEF;

        // Reset during RESP aborts the read and clears the counter.
        req0_valid = 1'b1; req0_addr = 3'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", rsp0_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   rsp0_valid, 0);
        chk("mid_rst_data",    rsp0_data, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        chk("post_rst_valid", rsp0_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 3'd0;  req1_addr = 3'd0;
        #1;
        chk("post_rst_r0_ready", req0_ready, 1);
        chk("post_rst_r1_ready", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_valid", rsp0_valid, 0);

        // Saturation: preload near the top, then keep reading invalid addresses.
        force dut.err_cnt_q = 16'hFFFD;
        #1;
        release dut.err_cnt_q;
        @(negedge clk);
        read_txn(1'b1, 3'd7, 32'h0, 1'b1);
        chk("sat_fffe", err_cnt, 16'hFFFE);
        read_txn(1'b1, 3'd6, 32'h0, 1'b1);
        chk("sat_ffff", err_cnt, 16'hFFFF);
        read_txn(1'b0, 3'd7, 32'h0, 1'b1);
        chk("sat_hold1", err_cnt, 16'hFFFF);
        read_txn(1'b1, 3'd7, 32'h0, 1'b1);
        chk("sat_hold2", err_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
